// File: rtl/bitmap_crypto_host.sv
// bitmap_crypto_host: buffers a bitmap, runs one engine job over it in place, then streams the results out.
module bitmap_crypto_host #(
  parameter int BITMAP_SIZE_BITS = 512,
  parameter int BITMAP_MEM_WIDTH = 128,
  parameter int MAX_BITMAP_MEM_DEPTH = (BITMAP_SIZE_BITS + BITMAP_MEM_WIDTH - 1) / BITMAP_MEM_WIDTH,
  localparam int W = BITMAP_MEM_WIDTH,
  localparam int D = MAX_BITMAP_MEM_DEPTH,
  localparam int AW = D > 1 ? $clog2(D) : 1,
  localparam int PW = $clog2(D + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [W-1:0]  key_in,
  input  logic          mode,
  input  logic [AW-1:0] last_addr,
  input  logic          cmd_start,
  input  logic [W-1:0]  in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [W-1:0]  eng_din,
  input  logic [AW-1:0] eng_addr,
  input  logic [W-1:0]  eng_dout,
  input  logic          eng_dout_valid,
  output logic [AW-1:0] eng_bit_map_depth,
  output logic [W-1:0]  eng_key,
  output logic          eng_init,
  output logic          eng_start,
  output logic          eng_start_encr,
  input  logic          eng_ready,
  input  logic          eng_done,
  input  logic          eng_done_init
);
  typedef enum logic [2:0] {IDLE, INIT, WAIT_INIT, WAIT_RDY, START, RUN, DRAIN} state_t;
  state_t state, next;
  logic [W-1:0] mem [D];
  logic [PW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic mode_r, live, cmd_ok, in_acc;
  assign cmd_ok = state == IDLE && cmd_start && wr_ptr > PW'(last_addr) && 32'(last_addr) < D;
  // live keeps in_ready low while reset is held and rises on the first edge after release
  assign in_ready = live && state == IDLE && wr_ptr != PW'(D);
  assign in_acc = in_valid && in_ready;
  assign done = state == DRAIN && out_valid && out_ready && rd_ptr == eng_bit_map_depth;
  assign busy = state != IDLE;
  assign eng_init = state == INIT;
  assign eng_start = state == START;
  always_comb begin
    next = state;
    case (state)
      IDLE:      next = cmd_ok ? INIT : IDLE;
      INIT:      next = WAIT_INIT;
      WAIT_INIT: next = eng_done_init ? WAIT_RDY : WAIT_INIT;
      WAIT_RDY:  next = eng_ready ? START : WAIT_RDY;
      START:     next = RUN;
      RUN:       next = eng_done ? DRAIN : RUN;
      DRAIN:     next = done ? IDLE : DRAIN;
      default:   next = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= next;
  always_ff @(posedge clock)
    if (in_acc) mem[wr_ptr[AW-1:0]] <= in_data;
    else if (state == RUN && eng_dout_valid) mem[eng_addr] <= eng_dout;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      live <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      eng_din <= '0;
      eng_key <= '0;
      eng_bit_map_depth <= '0;
      mode_r <= 1'b0;
      eng_start_encr <= 1'b0;
      err <= 1'b0;
    end else begin
      live <= 1'b1;
      err <= cmd_start && !cmd_ok;
      eng_din <= mem[eng_addr];
      if (in_acc) wr_ptr <= wr_ptr + 1'b1;
      if (cmd_ok) begin
        eng_key <= key_in;
        mode_r <= mode;
        eng_bit_map_depth <= last_addr;
      end
      // engine picks decrypt as !start_encr, so hold it for the whole run
      if (state == WAIT_RDY && eng_ready && mode_r) eng_start_encr <= 1'b1;
      if (state == RUN && eng_done) begin
        eng_start_encr <= 1'b0;
        rd_ptr <= '0;
      end
      if (state == DRAIN) begin
        if (!out_valid) begin
          out_data <= mem[rd_ptr];
          out_valid <= 1'b1;
        end else if (out_ready) begin
          if (done) begin
            out_valid <= 1'b0;
            wr_ptr <= '0;
          end else begin
            out_data <= mem[rd_ptr + 1'b1];
            rd_ptr <= rd_ptr + 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_bitmap_crypto_host.sv
// tb_bitmap_crypto_host: random jobs against an XOR engine model and an expected-output queue.
module tb_bitmap_crypto_host;
  logic clock = 0, reset = 0;
  logic [127:0] key_in = '0, in_data = '0, out_data, eng_din, eng_dout = '0, eng_key;
  logic mode = 0, cmd_start = 0, in_valid = 0, in_ready, out_valid, out_ready = 0;
  logic busy, done, err, eng_dout_valid = 0, eng_init, eng_start, eng_start_encr;
  logic eng_ready = 1, eng_done = 0, eng_done_init = 0;
  logic [1:0] last_addr = '0, eng_addr = '0, eng_bit_map_depth;
  int n_chk = 0, n_fail = 0, n_init = 0, n_done = 0, encr_hi = 0;
  logic enc_at_start, enc_at_done;
  logic [127:0] words[$], exp_q[$];

  bitmap_crypto_host dut (.clock(clock), .reset(reset), .key_in(key_in), .mode(mode),
    .last_addr(last_addr), .cmd_start(cmd_start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .err(err), .eng_din(eng_din), .eng_addr(eng_addr),
    .eng_dout(eng_dout), .eng_dout_valid(eng_dout_valid), .eng_bit_map_depth(eng_bit_map_depth),
    .eng_key(eng_key), .eng_init(eng_init), .eng_start(eng_start), .eng_start_encr(eng_start_encr),
    .eng_ready(eng_ready), .eng_done(eng_done), .eng_done_init(eng_done_init));

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (eng_init) n_init++;
    if (done) n_done++;
    if (eng_start_encr) encr_hi++;
    if (eng_start) enc_at_start = eng_start_encr;
    if (eng_done) enc_at_done = eng_start_encr;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // engine: init takes 2 cycles; each word waits 2 cycles after its address, then writes din^key or din^~key
  task automatic eng_loop();
    forever begin
      @(posedge clock); #1;
      if (eng_init) begin
        repeat (2) @(posedge clock);
        #1 eng_done_init = 1;
        @(posedge clock);
        #1 eng_done_init = 0;
      end else if (eng_start) begin
        for (int a = 0; a <= int'(eng_bit_map_depth); a++) begin
          eng_addr = 2'(a);
          repeat (2) @(posedge clock);
          #1 eng_dout = eng_din ^ (eng_start_encr ? eng_key : ~eng_key);
          eng_dout_valid = 1;
          @(posedge clock);
          #1 eng_dout_valid = 0;
        end
        eng_done = 1;
        @(posedge clock);
        #1 eng_done = 0;
        eng_addr = '0;
      end
    end
  endtask

  initial forever begin
    wait (reset);
    fork
      eng_loop();
      @(negedge reset);
    join_any
    disable fork;
    eng_done_init = 0; eng_done = 0; eng_dout_valid = 0; eng_addr = '0;
  end

  task automatic load(input logic [127:0] w);
    int t = 0;
    in_data = w;
    in_valid = 1;
    while (!in_ready && t < 20) begin
      @(posedge clock); #1;
      t++;
    end
    if (t == 20) chk("load_timeout", in_ready, 1);
    @(posedge clock); #1;
    in_valid = 0;
    words.push_back(w);
  endtask

  task automatic pulse_cmd(input logic m, input logic [127:0] k, input logic [1:0] la);
    mode = m; key_in = k; last_addr = la; cmd_start = 1;
    @(posedge clock); #1;
    cmd_start = 0;
  endtask

  task automatic wait_start();
    int t = 0;
    while (!eng_start && t < 50) begin
      @(posedge clock); #1;
      t++;
    end
    chk("eng_start_seen", eng_start, 1);
  endtask

  task automatic drain(input bit rnd);
    int t = 0;
    bit stall = 0;
    logic [127:0] sd = '0;
    while (exp_q.size() > 0 && t < 500) begin
      @(posedge clock);
      #1 out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, sd);
      end
      stall = out_valid && !out_ready;
      sd = out_data;
      if (out_valid && out_ready) begin
        chk("out_data", out_data, exp_q.pop_front());
        chk("done_at_last", done, exp_q.size() == 0);
      end
      t++;
    end
    chk("drain_left", exp_q.size(), 0);
    @(posedge clock); #1;
    out_ready = 0;
    chk("out_valid_after", out_valid, 0);
  endtask

  task automatic run_job(input logic m, input logic [127:0] k, input logic [1:0] la,
                         input bit rnd, input bit poke);
    int i0 = n_init, d0 = n_done;
    encr_hi = 0; enc_at_start = 0; enc_at_done = 0;
    for (int i = 0; i <= int'(la); i++) exp_q.push_back(words[i] ^ (m ? k : ~k));
    pulse_cmd(m, k, la);
    chk("init_latency", eng_init, 1);
    chk("busy_start", busy, 1);
    if (poke) begin
      wait_start();
      repeat (2) @(posedge clock);
      #1 cmd_start = 1;
      @(posedge clock); #1;
      cmd_start = 0;
      chk("err_mid_run", err, 1);
    end
    drain(rnd);
    chk("done_count", n_done - d0, 1);
    chk("init_count", n_init - i0, 1);
    chk("encr_at_start", enc_at_start, m);
    chk("encr_at_done", enc_at_done, m);
    if (!m) chk("encr_never_hi", encr_hi, 0);
    chk("encr_low_after", eng_start_encr, 0);
    chk("busy_after", busy, 0);
    words.delete();
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] k;
    logic [1:0] la;
    int i0;
    #1;
    chk("rst_ctrl", {busy, in_ready, out_valid, done, err, eng_init, eng_start, eng_start_encr}, 0);
    repeat (3) @(posedge clock);
    @(negedge clock) reset = 1;
    @(posedge clock); #1;
    chk("in_ready_after_rst", in_ready, 1);

    k = rnd128();
    for (int i = 1; i <= 4; i++) load(128'(i));
    chk("full_in_ready", in_ready, 0);
    run_job(1, k, 2'd3, 0, 0);

    for (int i = 1; i <= 4; i++) load(128'(i));
    run_job(0, k, 2'd3, 0, 0);

    load(rnd128()); load(rnd128());
    i0 = n_init;
    pulse_cmd(1, k, 2'd3);
    chk("err_short", err, 1);
    chk("busy_short", busy, 0);
    repeat (3) @(posedge clock);
    #1 chk("no_init_short", n_init - i0, 0);
    load(rnd128()); load(rnd128());
    run_job(1, rnd128(), 2'd3, 1, 0);

    for (int j = 0; j < 6; j++) begin
      la = 2'($urandom_range(0, 3));
      for (int i = 0; i <= int'(la); i++) load(rnd128());
      run_job(1'($urandom_range(0, 1)), rnd128(), la, 1, j % 2 == 1);
    end

    for (int i = 0; i < 4; i++) load(rnd128());
    pulse_cmd(1, rnd128(), 2'd3);
    wait_start();
    repeat (2) @(posedge clock);
    #3 reset = 0;
    #1;
    chk("rst_mid_ctrl", {busy, in_ready, out_valid, done, err, eng_init, eng_start, eng_start_encr}, 0);
    chk("rst_mid_din", eng_din, 0);
    chk("rst_mid_key", eng_key, 0);
    chk("rst_mid_out", out_data, 0);
    chk("rst_mid_depth", eng_bit_map_depth, 0);
    words.delete();
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1;
    @(posedge clock); #1;
    chk("in_ready_after_mid_rst", in_ready, 1);
    for (int i = 0; i < 4; i++) load(rnd128());
    chk("full_after_rst", in_ready, 0);
    run_job(0, rnd128(), 2'd3, 1, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
endmodule
